// File: rtl/dvs_event_timestamper.sv
`default_nettype none
// ============================================================================
//  Module   : dvs_event_timestamper
//  Purpose  : Free-running microsecond timestamp generator plus DVS address
//             event packer. Raw (x, y, pol) events arrive over valid/ready,
//             are range-checked against the sensor geometry, stamped with the
//             current microsecond count and emitted as {x, y, pol, ts_us}.
//             Out-of-range events are accepted and discarded. A saturating
//             counter keeps track of how many were discarded.
//  Revision : 1.0  initial release
// ============================================================================
module dvs_event_timestamper #(
    parameter int WIDTH_PXLS    = 346,
    parameter int HEIGHT_PXLS   = 260,
    parameter int CLK_PERIOD_NS = 10,
    parameter int TS_BITS       = 48,
    parameter int DROP_CNT_BITS = 16,
    localparam int X_BITS       = $clog2(WIDTH_PXLS),
    localparam int Y_BITS       = $clog2(HEIGHT_PXLS),
    localparam int EVENT_BITS   = X_BITS + Y_BITS + 1 + TS_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ts_clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [X_BITS-1:0]        in_x,
    input  logic [Y_BITS-1:0]        in_y,
    input  logic                     in_pol,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EVENT_BITS-1:0]    out_event,
    output logic [TS_BITS-1:0]       ts_us,
    output logic                     ts_wrap,
    output logic [DROP_CNT_BITS-1:0] drop_cnt
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // Clock cycles per microsecond; CLK_PERIOD_NS is expected to divide 1000
    // and leave DIV >= 2 so the prescaler is at least one bit wide.
    localparam int DIV      = 1000 / CLK_PERIOD_NS;
    localparam int PRE_BITS = $clog2(DIV);

    localparam logic [PRE_BITS-1:0] PRE_MAX = PRE_BITS'(DIV - 1);

    // Limits carry one extra bit so a sensor dimension that is an exact power
    // of two is still representable.
    localparam logic [X_BITS:0] X_LIMIT = (X_BITS + 1)'(WIDTH_PXLS);
    localparam logic [Y_BITS:0] Y_LIMIT = (Y_BITS + 1)'(HEIGHT_PXLS);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PRE_BITS-1:0]      pre_q,       pre_d;
    logic [TS_BITS-1:0]       ts_q,        ts_d;
    logic                     wrap_q,      wrap_d;
    logic                     out_valid_q, out_valid_d;
    logic [EVENT_BITS-1:0]    out_event_q, out_event_d;
    logic [DROP_CNT_BITS-1:0] drop_q,      drop_d;

    logic w_tick;
    logic w_accept;
    logic w_in_range;
    logic w_in_ready;

    // ------------------------------------------------------------------------
    // Handshake and classification
    // ------------------------------------------------------------------------
    // The output register can take a new word whenever it is empty or is
    // being drained this cycle, which gives full throughput.
    assign w_in_ready = !out_valid_q || out_ready;
    assign w_accept   = in_valid && w_in_ready;
    assign w_in_range = ({1'b0, in_x} < X_LIMIT) && ({1'b0, in_y} < Y_LIMIT);
    assign w_tick     = (pre_q == PRE_MAX);

    // Prescaler / timestamp next state; a clear overrides increment and wrap.
    always_comb begin
        pre_d  = w_tick ? '0 : pre_q + 1'b1;
        ts_d   = w_tick ? ts_q + 1'b1 : ts_q;
        wrap_d = w_tick && (ts_q == '1);
        if (ts_clear) begin
            pre_d  = '0;
            ts_d   = '0;
            wrap_d = 1'b0;
        end
    end

    // Output register next state: drain, then optionally refill with a new
    // in-range word stamped with the timestamp visible this cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_event_d = out_event_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (w_accept && w_in_range) begin
            out_valid_d = 1'b1;
            out_event_d = {in_x, in_y, in_pol, ts_q};
        end
    end

    // Dropped-event counter next state; saturates rather than wrapping.
    always_comb begin
        drop_d = drop_q;
        if (w_accept && !w_in_range && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Timestamp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            ts_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            ts_q   <= ts_d;
            wrap_q <= wrap_d;
        end
    end

    // Output stage and drop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_event_q <= '0;
            drop_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_event_q <= out_event_d;
            drop_q      <= drop_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = out_valid_q;
    assign out_event = out_event_q;
    assign ts_us     = ts_q;
    assign ts_wrap   = wrap_q;
    assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_dvs_event_timestamper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvs_event_timestamper
//  Purpose  : Directed self-checking bench. One default-parameter instance
//             for timing, packing, back-pressure and reset; one small
//             instance (DIV=2, 8-bit timestamp, 2-bit drop counter, 3x3
//             sensor) for wrap, clear priority and drop-counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dvs_event_timestamper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance signals
    logic        rst, ts_clear, in_valid, in_ready, in_pol, out_valid, out_ready, ts_wrap;
    logic [8:0]  in_x, in_y;
    logic [66:0] out_event;
    logic [47:0] ts_us;
    logic [15:0] drop_cnt;

    // Small instance signals
    logic        s_rst, s_ts_clear, s_in_valid, s_in_ready, s_in_pol, s_out_valid, s_out_ready, s_ts_wrap;
    logic [1:0]  s_in_x, s_in_y;
    logic [12:0] s_out_event;
    logic [7:0]  s_ts_us;
    logic [1:0]  s_drop_cnt;

    dvs_event_timestamper u_dut (
        .clk       (clk),
        .rst       (rst),
        .ts_clear  (ts_clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_pol    (in_pol),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_event (out_event),
        .ts_us     (ts_us),
        .ts_wrap   (ts_wrap),
        .drop_cnt  (drop_cnt)
    );

    dvs_event_timestamper #(
        .WIDTH_PXLS    (3),
        .HEIGHT_PXLS   (3),
        .CLK_PERIOD_NS (500),
        .TS_BITS       (8),
        .DROP_CNT_BITS (2)
    ) u_small (
        .clk       (clk),
        .rst       (s_rst),
        .ts_clear  (s_ts_clear),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_x      (s_in_x),
        .in_y      (s_in_y),
        .in_pol    (s_in_pol),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_event (s_out_event),
        .ts_us     (s_ts_us),
        .ts_wrap   (s_ts_wrap),
        .drop_cnt  (s_drop_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ts_clear = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_pol = 1'b0;
        out_ready = 1'b1;
        s_rst = 1'b1; s_ts_clear = 1'b0; s_in_valid = 1'b0; s_in_x = '0; s_in_y = '0;
        s_in_pol = 1'b0; s_out_ready = 1'b1;

        // ---------------- reset state ----------------
        step(3);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_ts_us",     ts_us,     0);
        check_eq("rst_ts_wrap",   ts_wrap,   0);
        check_eq("rst_drop_cnt",  drop_cnt,  0);
        check_eq("rst_in_ready",  in_ready,  1);
        check_eq("rst_out_event", out_event, 0);

        // ---------------- prescaler phase ----------------
        // After edge k following release: ts_us = k/100.
        @(negedge clk) rst = 1'b0;
        step(99);
        check_eq("ts_at_99",   ts_us, 0);
        step(1);
        check_eq("ts_at_100",  ts_us, 1);
        step(900);
        check_eq("ts_at_1000", ts_us, 10);

        // ---------------- clear, then advance to ts_us = 7 ----------------
        ts_clear = 1'b1;
        step(1);
        ts_clear = 1'b0;
        check_eq("ts_after_clear", ts_us, 0);
        step(700);
        check_eq("ts_at_7", ts_us, 7);
        check_eq("drop_kept_by_clear", drop_cnt, 0);

        // ---------------- corner in-range event ----------------
        in_valid = 1'b1; in_x = 9'd345; in_y = 9'd259; in_pol = 1'b1;
        #1 check_eq("in_ready_idle", in_ready, 1);
        step(1);
        check_eq("corner_valid", out_valid, 1);
        check_eq("corner_event", out_event, {9'd345, 9'd259, 1'b1, 48'd7});

        // ---------------- out-of-range x, then y ----------------
        in_x = 9'd346; in_y = 9'd0; in_pol = 1'b0;
        step(1);
        check_eq("oob_x_valid", out_valid, 0);
        check_eq("oob_x_drop",  drop_cnt,  1);
        in_x = 9'd0; in_y = 9'd260;
        step(1);
        check_eq("oob_y_valid", out_valid, 0);
        check_eq("oob_y_drop",  drop_cnt,  2);

        // ---------------- stall for 50 cycles ----------------
        // Prescaler stays well below 99 through the rest of this section,
        // so every captured timestamp below is 7.
        out_ready = 1'b0;
        in_x = 9'd10; in_y = 9'd20; in_pol = 1'b0;
        step(1);
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_event", out_event, {9'd10, 9'd20, 1'b0, 48'd7});
        in_x = 9'd11; in_y = 9'd21; in_pol = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            check_eq("stall_in_ready", in_ready, 0);
            step(1);
            check_eq("stall_hold_event", out_event, {9'd10, 9'd20, 1'b0, 48'd7});
            check_eq("stall_hold_valid", out_valid, 1);
        end

        // ---------------- back-to-back release ----------------
        out_ready = 1'b1;
        #1 check_eq("release_in_ready", in_ready, 1);
        step(1);
        check_eq("b2b1_valid", out_valid, 1);
        check_eq("b2b1_event", out_event, {9'd11, 9'd21, 1'b1, 48'd7});
        in_x = 9'd12; in_y = 9'd22; in_pol = 1'b0;
        step(1);
        check_eq("b2b2_valid", out_valid, 1);
        check_eq("b2b2_event", out_event, {9'd12, 9'd22, 1'b0, 48'd7});
        in_valid = 1'b0;
        step(1);
        check_eq("drain_valid", out_valid, 0);

        // ---------------- asynchronous reset while stalled ----------------
        out_ready = 1'b0; in_valid = 1'b1; in_x = 9'd1; in_y = 9'd2; in_pol = 1'b0;
        step(1);
        in_valid = 1'b0;
        check_eq("pre_rst_valid", out_valid, 1);
        check_eq("pre_rst_drop",  drop_cnt,  2);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_ts",    ts_us,     0);
        check_eq("async_rst_drop",  drop_cnt,  0);
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_x = 9'd3; in_y = 9'd4; in_pol = 1'b1;
        step(1);
        in_valid = 1'b0;
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_event", out_event, {9'd3, 9'd4, 1'b1, 48'd0});

        // ---------------- small instance: wrap ----------------
        // DIV = 2: after edge k following release, ts_us = (k/2) mod 256.
        @(negedge clk) s_rst = 1'b0;
        step(511);
        check_eq("s_ts_255",        s_ts_us,   255);
        check_eq("s_wrap_before",   s_ts_wrap, 0);
        step(1);
        check_eq("s_ts_wrapped",    s_ts_us,   0);
        check_eq("s_wrap_pulse",    s_ts_wrap, 1);
        step(1);
        check_eq("s_wrap_one_cycle", s_ts_wrap, 0);

        // ---------------- small instance: clear on the wrap edge ----------------
        step(510);
        check_eq("s_ts_255_again", s_ts_us, 255);
        s_ts_clear = 1'b1;
        step(1);
        s_ts_clear = 1'b0;
        check_eq("s_clear_ts",      s_ts_us,   0);
        check_eq("s_clear_no_wrap", s_ts_wrap, 0);
        step(1);
        check_eq("s_clear_phase0",  s_ts_us,   0);
        step(1);
        check_eq("s_clear_phase1",  s_ts_us,   1);

        // ---------------- small instance: drop saturation ----------------
        s_in_valid = 1'b1; s_in_x = 2'd3; s_in_y = 2'd0;
        step(1); check_eq("s_drop_1", s_drop_cnt, 1);
        step(1); check_eq("s_drop_2", s_drop_cnt, 2);
        s_in_x = 2'd0; s_in_y = 2'd3;
        step(1); check_eq("s_drop_3", s_drop_cnt, 3);
        step(1); check_eq("s_drop_sat4", s_drop_cnt, 3);
        step(1); check_eq("s_drop_sat5", s_drop_cnt, 3);
        check_eq("s_drop_no_out", s_out_valid, 0);
        s_in_x = 2'd2; s_in_y = 2'd2; s_in_pol = 1'b1;
        step(1);
        s_in_valid = 1'b0;
        check_eq("s_edge_valid", s_out_valid, 1);
        check_eq("s_edge_event", s_out_event[12:8], {2'd2, 2'd2, 1'b1});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
